bru_iq_single: RTL
==================

// Module: bru_iq_single
// PURPOSE
// Branch-unit issue queue: the producer side of the BRU issue valid/ready interface.
// - Accepts one dispatched branch/jump op per cycle and holds it until its source operands are ready.
// - Issues the oldest ready op when the BRU pipeline asserts issue_ready, with per-operand forward/bank info and PRF read requests.
// - Sits between dispatch/rename and bru_pipeline; wakeup comes from the PRF writeback broadcast.
// PARAMETERS
// BRU_IQ_ENTRIES   4   queue depth; entry 0 is the oldest
// PORTS
// CLK                                  in   1    clock
// RST                                  in   1    reset
// dispatch_valid                       in   1    dispatch op present
// dispatch_op/pred_info/pred_lru/is_link_ra/is_ret_ra/PC/pred_PC/imm20   in   4/BTB_PRED_INFO_WIDTH/1/1/1/32/32/20   op payload
// dispatch_A_unneeded_or_is_zero, dispatch_B_unneeded_or_is_zero         in   1 each   operand needs no read
// dispatch_A_PR, dispatch_B_PR         in   LOG_PR_COUNT each   source physical regs
// dispatch_A_ready, dispatch_B_ready   in   1 each   source already written at rename
// dispatch_dest_PR, dispatch_ROB_index in   LOG_PR_COUNT/LOG_ROB_ENTRIES   destination and ROB tag
// dispatch_ready                       out  1    a free entry exists
// WB_bus_valid_by_bank                 in   PRF_BANK_COUNT   writeback-broadcast valid per bank
// WB_bus_upper_PR_by_bank              in   PRF_BANK_COUNT x (LOG_PR_COUNT-LOG_PRF_BANK_COUNT)   broadcast PR upper bits
// rollback_valid, rollback_ROB_index, ROB_head_index   in   1/LOG_ROB_ENTRIES/LOG_ROB_ENTRIES   kill request
// issue_valid ... issue_ROB_index      out  same fields/widths as the bru_pipeline issue port   issued op
// issue_ready                          in   1    BRU pipeline accepts the issue
// PRF_req_A_valid, PRF_req_A_PR, PRF_req_B_valid, PRF_req_B_PR   out  1/LOG_PR_COUNT each   register-read requests
// BEHAVIOUR
// Interface: one clock; reset is asynchronous and active-high.
// Reset
// - All entries invalid; issue_valid = 0; PRF_req_*_valid = 0; dispatch_ready = 1.
// - Asserting RST mid-operation drops every queued op immediately.
// Per-entry state
// - valid, payload, A/B PR, A/B ready.
// - Bank of an operand = PR[LOG_PRF_BANK_COUNT-1:0].
// Wakeup
// - An operand matches when WB_bus_valid_by_bank[bank] is set and WB_bus_upper_PR_by_bank[bank] equals the PR upper bits.
// - A match sets the operand's ready bit at the next edge.
// Eligibility
// - An entry is eligible when valid and, for each operand, the operand is unneeded, its ready bit is set, or it matches a wakeup this cycle.
// - issue_X_forward = 1 only when the operand became ready via a wakeup match this cycle (not already-ready, not unneeded).
// Selection and issue outputs
// - Combinational pick of the lowest-index eligible entry.
// - issue_valid = any entry eligible.
// - issue_A_bank/issue_B_bank = operand bank.
// - PRF_req_X_valid = issue_valid & issue_ready & ~unneeded & ~forward; PRF_req_X_PR = operand PR.
// Handshake
// - A selected entry leaves only when issue_valid & issue_ready.
// - When issue_ready = 0, outputs may change as wakeups arrive; there is no hold requirement.
// Compaction
// - On issue, entries above the issued index shift down one slot, keeping their age order.
// - A same-cycle dispatch is written at the first free slot after the shift.
// - Full queue: dispatch_ready = 0, except the cycle a full queue issues, when dispatch_ready = 1.
// Dispatch
// - The dispatched entry's ready bits are dispatch_X_ready OR a same-cycle wakeup match.
// - A dispatched op is never issued in its dispatch cycle; earliest issue is the next cycle.
// Rollback
// - Kills every valid entry with (ROB_index - ROB_head_index) >= (rollback_ROB_index - ROB_head_index), modulo 2^LOG_ROB_ENTRIES.
// - Survivors compact toward index 0.
// - Issue and dispatch are suppressed in a rollback cycle.
// Width
// - ROB age compares use LOG_ROB_ENTRIES-bit wrap subtraction.
// STRUCTURE
// Package
// - BRU_IQ_ENTRIES default and a bru_iq_entry_t struct (payload + PRs + ready bits) go in core_types_pkg.
// - BTB_PRED_INFO_WIDTH, LOG_PR_COUNT, LOG_ROB_ENTRIES, PRF_BANK_COUNT and LOG_PRF_BANK_COUNT are taken from core_types_pkg.
// Sub-module
// - One natural sub-module: pe_lsb, a parameterized lowest-set-bit one-hot priority encoder used for issue select and first-free-slot select.
// TESTING
// 1. Reset pulse mid-stream with 3 entries queued -> the next cycle shows issue_valid=0 and dispatch_ready=1.
// 2. Dispatch op with A_ready=B_ready=1, ROB 5 -> issue_valid the next cycle, ROB_index=5, forward=0, PRF_req_A/B_valid=1 while issue_ready=1.
// 3. Entry waiting on A_PR=0x23 (bank 3 of 4); broadcast bank 3 upper=0x8 -> same-cycle issue with issue_A_forward=1, issue_A_bank=3, PRF_req_A_valid=0.
// 4. Fill 4 entries (dispatch_ready=0); issue entry 1 while dispatching ROB 9 -> order becomes 0,2,3,9; dispatch_ready=1 in that cycle.
// 5. issue_ready=0 for 3 cycles with 2 ready entries -> nothing dequeued; when issue_ready rises, oldest issues first.
// 6. Head=30, entries ROB 30,31,0,1 (32-entry ROB); rollback at ROB 0 -> only 30,31 remain; no issue in the rollback cycle.

Source files
------------

// File: rtl/core_types_pkg.sv
// Core-wide widths plus the BRU issue-queue entry type and writeback wakeup match helper.
package core_types_pkg;

    localparam int unsigned BTB_PRED_INFO_WIDTH = 8;
    localparam int unsigned LOG_PR_COUNT        = 7;
    localparam int unsigned LOG_ROB_ENTRIES     = 5;
    localparam int unsigned PRF_BANK_COUNT      = 4;
    localparam int unsigned LOG_PRF_BANK_COUNT  = 2;
    localparam int unsigned UPPER_PR_WIDTH      = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;
    localparam int unsigned BRU_IQ_ENTRIES      = 4;

    typedef logic [LOG_PR_COUNT-1:0]                             pr_t;
    typedef logic [PRF_BANK_COUNT-1:0][UPPER_PR_WIDTH-1:0]       wb_upper_t;

    typedef struct packed {
        logic [3:0]                     op;
        logic [BTB_PRED_INFO_WIDTH-1:0] pred_info;
        logic                           pred_lru;
        logic                           is_link_ra;
        logic                           is_ret_ra;
        logic [31:0]                    PC;
        logic [31:0]                    pred_PC;
        logic [19:0]                    imm20;
        logic                           A_unneeded;
        logic                           B_unneeded;
        pr_t                            A_PR;
        pr_t                            B_PR;
        logic                           A_ready;
        logic                           B_ready;
        pr_t                            dest_PR;
        logic [LOG_ROB_ENTRIES-1:0]     ROB_index;
    } bru_iq_entry_t;

    // Operand wakes when its bank broadcasts a matching upper PR.
    function automatic logic wb_match(pr_t pr, logic [PRF_BANK_COUNT-1:0] wb_valid,
                                      wb_upper_t wb_upper);
        logic [LOG_PRF_BANK_COUNT-1:0] bank;
        bank = pr[LOG_PRF_BANK_COUNT-1:0];
        return wb_valid[bank] && (wb_upper[bank] == pr[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT]);
    endfunction

endpackage

// File: rtl/bru_iq_single_if.sv
// Dispatch, wakeup, rollback, issue and PRF-read signals of the BRU issue queue.
interface bru_iq_single_if;
    import core_types_pkg::*;

    logic                               dispatch_valid;
    logic [3:0]                         dispatch_op;
    logic [BTB_PRED_INFO_WIDTH-1:0]     dispatch_pred_info;
    logic                               dispatch_pred_lru;
    logic                               dispatch_is_link_ra;
    logic                               dispatch_is_ret_ra;
    logic [31:0]                        dispatch_PC;
    logic [31:0]                        dispatch_pred_PC;
    logic [19:0]                        dispatch_imm20;
    logic                               dispatch_A_unneeded_or_is_zero;
    logic                               dispatch_B_unneeded_or_is_zero;
    pr_t                                dispatch_A_PR;
    pr_t                                dispatch_B_PR;
    logic                               dispatch_A_ready;
    logic                               dispatch_B_ready;
    pr_t                                dispatch_dest_PR;
    logic [LOG_ROB_ENTRIES-1:0]         dispatch_ROB_index;
    logic                               dispatch_ready;

    logic [PRF_BANK_COUNT-1:0]          WB_bus_valid_by_bank;
    wb_upper_t                          WB_bus_upper_PR_by_bank;

    logic                               rollback_valid;
    logic [LOG_ROB_ENTRIES-1:0]         rollback_ROB_index;
    logic [LOG_ROB_ENTRIES-1:0]         ROB_head_index;

    logic                               issue_valid;
    logic [3:0]                         issue_op;
    logic [BTB_PRED_INFO_WIDTH-1:0]     issue_pred_info;
    logic                               issue_pred_lru;
    logic                               issue_is_link_ra;
    logic                               issue_is_ret_ra;
    logic [31:0]                        issue_PC;
    logic [31:0]                        issue_pred_PC;
    logic [19:0]                        issue_imm20;
    logic                               issue_A_unneeded_or_is_zero;
    logic                               issue_A_forward;
    logic [LOG_PRF_BANK_COUNT-1:0]      issue_A_bank;
    logic                               issue_B_unneeded_or_is_zero;
    logic                               issue_B_forward;
    logic [LOG_PRF_BANK_COUNT-1:0]      issue_B_bank;
    pr_t                                issue_dest_PR;
    logic [LOG_ROB_ENTRIES-1:0]         issue_ROB_index;
    logic                               issue_ready;

    logic                               PRF_req_A_valid;
    pr_t                                PRF_req_A_PR;
    logic                               PRF_req_B_valid;
    pr_t                                PRF_req_B_PR;

    // master: the issue queue (producer of issue/PRF requests); slave: its environment.
    modport master (
        input  dispatch_valid, dispatch_op, dispatch_pred_info, dispatch_pred_lru,
               dispatch_is_link_ra, dispatch_is_ret_ra, dispatch_PC, dispatch_pred_PC,
               dispatch_imm20, dispatch_A_unneeded_or_is_zero, dispatch_B_unneeded_or_is_zero,
               dispatch_A_PR, dispatch_B_PR, dispatch_A_ready, dispatch_B_ready,
               dispatch_dest_PR, dispatch_ROB_index, WB_bus_valid_by_bank,
               WB_bus_upper_PR_by_bank, rollback_valid, rollback_ROB_index, ROB_head_index,
               issue_ready,
        output dispatch_ready, issue_valid, issue_op, issue_pred_info, issue_pred_lru,
               issue_is_link_ra, issue_is_ret_ra, issue_PC, issue_pred_PC, issue_imm20,
               issue_A_unneeded_or_is_zero, issue_A_forward, issue_A_bank,
               issue_B_unneeded_or_is_zero, issue_B_forward, issue_B_bank, issue_dest_PR,
               issue_ROB_index, PRF_req_A_valid, PRF_req_A_PR, PRF_req_B_valid, PRF_req_B_PR
    );

    modport slave (
        output dispatch_valid, dispatch_op, dispatch_pred_info, dispatch_pred_lru,
               dispatch_is_link_ra, dispatch_is_ret_ra, dispatch_PC, dispatch_pred_PC,
               dispatch_imm20, dispatch_A_unneeded_or_is_zero, dispatch_B_unneeded_or_is_zero,
               dispatch_A_PR, dispatch_B_PR, dispatch_A_ready, dispatch_B_ready,
               dispatch_dest_PR, dispatch_ROB_index, WB_bus_valid_by_bank,
               WB_bus_upper_PR_by_bank, rollback_valid, rollback_ROB_index, ROB_head_index,
               issue_ready,
        input  dispatch_ready, issue_valid, issue_op, issue_pred_info, issue_pred_lru,
               issue_is_link_ra, issue_is_ret_ra, issue_PC, issue_pred_PC, issue_imm20,
               issue_A_unneeded_or_is_zero, issue_A_forward, issue_A_bank,
               issue_B_unneeded_or_is_zero, issue_B_forward, issue_B_bank, issue_dest_PR,
               issue_ROB_index, PRF_req_A_valid, PRF_req_A_PR, PRF_req_B_valid, PRF_req_B_PR
    );

endinterface

// File: rtl/bru_iq_single_pe_lsb.sv
// Lowest-set-bit one-hot priority encoder (isolates the least significant request).
module pe_lsb #(
    parameter int unsigned Width = 4
) (
    input  logic [Width-1:0] req_i,
    output logic [Width-1:0] gnt_o
);

    assign gnt_o = req_i & (~req_i + Width'(1));

endmodule

// File: rtl/bru_iq_single.sv
// Age-ordered compacting BRU issue queue: entry 0 is oldest, issue picks the oldest ready op.
module bru_iq_single
    import core_types_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    bru_iq_single_if.master    iq_if
);

    localparam int unsigned N = BRU_IQ_ENTRIES;

    bru_iq_entry_t [N-1:0]               entries_q, entries_d, upd, shifted;
    logic [N-1:0]                        valid_q, valid_d, valid_shift;
    logic [N-1:0]                        a_wake, b_wake, eligible, issue_oh, ge_issue;
    logic [N-1:0]                        kill, free_oh;
    logic [N-1:0][LOG_ROB_ENTRIES-1:0]   ent_age;
    logic [LOG_ROB_ENTRIES-1:0]          rb_age;
    bru_iq_entry_t                       sel, new_entry;
    logic                                sel_a_wake, sel_b_wake, do_issue, do_dispatch;

    always_comb begin
        rb_age = iq_if.rollback_ROB_index - iq_if.ROB_head_index;
        for (int i = 0; i < N; i++) begin
            a_wake[i]     = wb_match(entries_q[i].A_PR, iq_if.WB_bus_valid_by_bank,
                                     iq_if.WB_bus_upper_PR_by_bank);
            b_wake[i]     = wb_match(entries_q[i].B_PR, iq_if.WB_bus_valid_by_bank,
                                     iq_if.WB_bus_upper_PR_by_bank);
            eligible[i]   = valid_q[i]
                          & (entries_q[i].A_unneeded | entries_q[i].A_ready | a_wake[i])
                          & (entries_q[i].B_unneeded | entries_q[i].B_ready | b_wake[i]);
            upd[i]         = entries_q[i];
            upd[i].A_ready = entries_q[i].A_ready | a_wake[i];
            upd[i].B_ready = entries_q[i].B_ready | b_wake[i];
            ent_age[i]     = entries_q[i].ROB_index - iq_if.ROB_head_index;
            kill[i]        = valid_q[i] & (ent_age[i] >= rb_age);
        end
    end

    pe_lsb #(.Width(N)) u_issue_pe (.req_i(eligible), .gnt_o(issue_oh));

    always_comb begin
        sel        = '0;
        sel_a_wake = 1'b0;
        sel_b_wake = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (issue_oh[i]) begin
                sel        = entries_q[i];
                sel_a_wake = a_wake[i];
                sel_b_wake = b_wake[i];
            end
        end
    end

    assign iq_if.issue_valid                 = (|eligible) & ~iq_if.rollback_valid;
    assign do_issue                          = iq_if.issue_valid & iq_if.issue_ready;
    assign iq_if.issue_op                    = sel.op;
    assign iq_if.issue_pred_info             = sel.pred_info;
    assign iq_if.issue_pred_lru              = sel.pred_lru;
    assign iq_if.issue_is_link_ra            = sel.is_link_ra;
    assign iq_if.issue_is_ret_ra             = sel.is_ret_ra;
    assign iq_if.issue_PC                    = sel.PC;
    assign iq_if.issue_pred_PC               = sel.pred_PC;
    assign iq_if.issue_imm20                 = sel.imm20;
    assign iq_if.issue_A_unneeded_or_is_zero = sel.A_unneeded;
    assign iq_if.issue_B_unneeded_or_is_zero = sel.B_unneeded;
    // Forward only when this cycle's broadcast is what made the operand ready.
    assign iq_if.issue_A_forward   = sel_a_wake & ~sel.A_ready & ~sel.A_unneeded;
    assign iq_if.issue_B_forward   = sel_b_wake & ~sel.B_ready & ~sel.B_unneeded;
    assign iq_if.issue_A_bank      = sel.A_PR[LOG_PRF_BANK_COUNT-1:0];
    assign iq_if.issue_B_bank      = sel.B_PR[LOG_PRF_BANK_COUNT-1:0];
    assign iq_if.issue_dest_PR     = sel.dest_PR;
    assign iq_if.issue_ROB_index   = sel.ROB_index;
    assign iq_if.PRF_req_A_valid   = do_issue & ~sel.A_unneeded & ~iq_if.issue_A_forward;
    assign iq_if.PRF_req_B_valid   = do_issue & ~sel.B_unneeded & ~iq_if.issue_B_forward;
    assign iq_if.PRF_req_A_PR      = sel.A_PR;
    assign iq_if.PRF_req_B_PR      = sel.B_PR;

    assign iq_if.dispatch_ready = ~(&valid_q) | do_issue;
    assign do_dispatch = iq_if.dispatch_valid & iq_if.dispatch_ready & ~iq_if.rollback_valid;

    always_comb begin
        new_entry            = '0;
        new_entry.op         = iq_if.dispatch_op;
        new_entry.pred_info  = iq_if.dispatch_pred_info;
        new_entry.pred_lru   = iq_if.dispatch_pred_lru;
        new_entry.is_link_ra = iq_if.dispatch_is_link_ra;
        new_entry.is_ret_ra  = iq_if.dispatch_is_ret_ra;
        new_entry.PC         = iq_if.dispatch_PC;
        new_entry.pred_PC    = iq_if.dispatch_pred_PC;
        new_entry.imm20      = iq_if.dispatch_imm20;
        new_entry.A_unneeded = iq_if.dispatch_A_unneeded_or_is_zero;
        new_entry.B_unneeded = iq_if.dispatch_B_unneeded_or_is_zero;
        new_entry.A_PR       = iq_if.dispatch_A_PR;
        new_entry.B_PR       = iq_if.dispatch_B_PR;
        new_entry.A_ready    = iq_if.dispatch_A_ready | wb_match(iq_if.dispatch_A_PR,
                               iq_if.WB_bus_valid_by_bank, iq_if.WB_bus_upper_PR_by_bank);
        new_entry.B_ready    = iq_if.dispatch_B_ready | wb_match(iq_if.dispatch_B_PR,
                               iq_if.WB_bus_valid_by_bank, iq_if.WB_bus_upper_PR_by_bank);
        new_entry.dest_PR    = iq_if.dispatch_dest_PR;
        new_entry.ROB_index  = iq_if.dispatch_ROB_index;
    end

    // Entries at and above the issued slot move down one, preserving age order.
    always_comb begin
        ge_issue[0] = issue_oh[0];
        for (int i = 1; i < N; i++) begin
            ge_issue[i] = ge_issue[i-1] | issue_oh[i];
        end
        shifted     = upd;
        valid_shift = valid_q;
        if (do_issue) begin
            for (int i = 0; i < N - 1; i++) begin
                if (ge_issue[i]) begin
                    shifted[i]     = upd[i+1];
                    valid_shift[i] = valid_q[i+1];
                end
            end
            if (ge_issue[N-1]) begin
                valid_shift[N-1] = 1'b0;
            end
        end
    end

    pe_lsb #(.Width(N)) u_free_pe (.req_i(~valid_shift), .gnt_o(free_oh));

    // Valid entries always form a prefix, so clearing killed ones leaves survivors compacted.
    always_comb begin
        entries_d = shifted;
        valid_d   = valid_shift;
        if (iq_if.rollback_valid) begin
            entries_d = upd;
            valid_d   = valid_q & ~kill;
        end else if (do_dispatch) begin
            for (int i = 0; i < N; i++) begin
                if (free_oh[i]) begin
                    entries_d[i] = new_entry;
                    valid_d[i]   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q   <= '0;
            entries_q <= '0;
        end else begin
            valid_q   <= valid_d;
            entries_q <= entries_d;
        end
    end

endmodule
